// File: rtl/s_box_inverse_if.sv
// Byte-wide valid/ready link into and out of the inverse S-box.
// The master side is the upstream/downstream pair; the slave side is the S-box.
interface s_box_inverse_if;
    logic       input_valid;
    logic       input_ready;
    logic [7:0] input_data;
    logic       output_valid;
    logic       output_ready;
    logic [7:0] output_data;

    modport master (
        output input_valid,
        output input_data,
        output output_ready,
        input  input_ready,
        input  output_valid,
        input  output_data
    );

    modport slave (
        input  input_valid,
        input  input_data,
        input  output_ready,
        output input_ready,
        output output_valid,
        output output_data
    );
endinterface

// File: rtl/s_box_inverse.sv
// Inverse AES S-box for one byte: inverse affine, then GF(2^8) inverse as x^254
// using one square and one multiply per cycle; one byte in flight at a time.
module s_box_inverse #(
    parameter logic [7:0] REDUCTION_POLY = 8'h1B
) (
    input  logic          clock,
    input  logic          reset,
    s_box_inverse_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic [7:0] sq_reg;
    logic [7:0] acc_reg;
    logic [7:0] out_data_reg;
    logic       out_valid_reg;
    logic       in_ready_reg;

    logic [7:0] affine_b;
    logic [7:0] affine_sq;
    logic [7:0] sq_next;
    logic [7:0] acc_next;

    // Carry-less shift-and-add multiply, reducing whenever bit 7 shifts out.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ REDUCTION_POLY) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // b = rotl(s,1) ^ rotl(s,3) ^ rotl(s,6) ^ 0x05, expressed bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_inv_affine
            assign affine_b[gi] = bus.input_data[(gi + 7) % 8]
                                ^ bus.input_data[(gi + 5) % 8]
                                ^ bus.input_data[(gi + 2) % 8]
                                ^ INV_AFFINE_C[gi];
        end
    endgenerate

    assign affine_sq = gf_mul(affine_b, affine_b);
    assign sq_next   = gf_mul(sq_reg, sq_reg);
    assign acc_next  = gf_mul(acc_reg, sq_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            sq_reg        <= 8'h00;
            acc_reg       <= 8'h00;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    if (bus.input_valid && in_ready_reg) begin
                        sq_reg       <= affine_sq;
                        acc_reg      <= affine_sq;
                        cnt_reg      <= 3'd0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // acc accumulates x^(2+4+...+2^k); the sixth step closes x^254.
                    sq_reg  <= sq_next;
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd5) begin
                        out_data_reg  <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.output_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.input_ready  = in_ready_reg;
    assign bus.output_valid = out_valid_reg;
    assign bus.output_data  = out_data_reg;

endmodule

// File: tb/tb_s_box_inverse.sv
// Self-checking bench for s_box_inverse: expected bytes go into a scoreboard queue
// at accept time and are compared against completed output handshakes.
module tb_s_box_inverse;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    s_box_inverse_if bus();

    s_box_inverse #(.REDUCTION_POLY(8'h1B)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    int         acc_q[$];
    logic [7:0] inv_tab[256];
    logic [7:0] fwd_tab[256];
    bit         stim_done;

    // Observe handshakes mid-cycle, where inputs and outputs are both stable.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.output_valid && bus.output_ready) out_q.push_back(bus.output_data);
            if (bus.input_valid && bus.input_ready) acc_q.push_back(cyc);
        end
    end

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15 - n -: 8];
    endfunction

    // Forward S-box by brute-force field inverse, then the inverse table from it.
    task automatic build_model();
        for (int y = 0; y < 256; y++) begin
            logic [7:0] yi = 8'h00;
            logic [7:0] f;
            for (int z = 1; z < 256; z++)
                if (ref_mul(8'(y), 8'(z)) == 8'h01) yi = 8'(z);
            f = yi ^ rotl8(yi, 1) ^ rotl8(yi, 2) ^ rotl8(yi, 3) ^ rotl8(yi, 4) ^ 8'h63;
            fwd_tab[y] = f;
            inv_tab[f] = 8'(y);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete(); in_q.delete(); out_q.delete(); acc_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.input_data  = d;
        bus.input_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.input_ready) break;
            if (n == 300) begin
                tests++; fails++;
                $display("FAIL push_timeout input=%02h never accepted", d);
                break;
            end
        end
        step();
        bus.input_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 3000 && out_q.size() < n; k++) @(posedge clk);
        if (out_q.size() < n) begin
            tests++; fails++;
            $display("FAIL drain_timeout got %0d results, need %0d", out_q.size(), n);
        end
        #1;
    endtask

    task automatic test_reset();
        bus.input_valid = 1'b0; bus.input_data = 8'h00; bus.output_ready = 1'b0;
        reset = 1'b1;
        step(); step();
        tests++;
        if (bus.output_valid !== 1'b0 || bus.output_data !== 8'h00 || bus.input_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state got valid=%b data=%02h ready=%b need 0/00/1",
                     bus.output_valid, bus.output_data, bus.input_ready);
        end
        reset = 1'b0;
        step();
        $display("[TB] reset done");
    endtask

    task automatic test_latency();
        clear_queues();
        bus.input_data = 8'h63; bus.input_valid = 1'b1; bus.output_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            tests++;
            if (bus.input_ready !== (k == 0 || k == 8)) begin
                fails++;
                $display("FAIL latency_input_ready cycle %0d got %b need %b", k, bus.input_ready, (k == 0 || k == 8));
            end
            tests++;
            if (bus.output_valid !== (k == 7)) begin
                fails++;
                $display("FAIL latency_output_valid cycle %0d got %b need %b", k, bus.output_valid, (k == 7));
            end
            if (k == 7) begin
                tests++;
                if (bus.output_data !== 8'h00) begin
                    fails++;
                    $display("FAIL latency_data got %02h need 00", bus.output_data);
                end
            end
            step();
            if (k == 0) bus.input_valid = 1'b0;
        end
        $display("[TB] latency: in=63 results=%0d", out_q.size());
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins[5]  = '{8'h00, 8'h7C, 8'hED, 8'h16, 8'h52};
        logic [7:0] outs[5] = '{8'h52, 8'h01, 8'h53, 8'hFF, 8'h48};
        clear_queues();
        bus.output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(outs[i]);
            push_byte(ins[i]);
        end
        drain(5);
        for (int i = 0; i < 5 && out_q.size() > 0; i++) begin
            logic [7:0] got = out_q.pop_front();
            logic [7:0] want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL b2b_data in=%02h got %02h need %02h", ins[i], got, want);
            end else $display("[TB] b2b in=%02h out=%02h", ins[i], got);
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            tests++;
            if (acc_q[i] - acc_q[i-1] != 8) begin
                fails++;
                $display("FAIL b2b_spacing accept %0d gap got %0d need 8", i, acc_q[i] - acc_q[i-1]);
            end
        end
        tests++;
        if (acc_q.size() != 5) begin
            fails++;
            $display("FAIL b2b_accepts got %0d need 5", acc_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_queues();
        bus.output_ready = 1'b0;
        push_byte(8'h7C);
        while (!bus.output_valid && n < 50) begin @(negedge clk); n++; end
        bus.input_data = 8'h99; bus.input_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== 8'h01 || bus.input_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold cycle %0d got valid=%b data=%02h ready=%b need 1/01/0",
                         k, bus.output_valid, bus.output_data, bus.input_ready);
            end
        end
        step();
        bus.output_ready = 1'b1; bus.input_valid = 1'b0;
        step();
        @(negedge clk);
        tests++;
        if (bus.output_valid !== 1'b0 || bus.output_data !== 8'h01 || bus.input_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release got valid=%b data=%02h ready=%b need 0/01/1",
                     bus.output_valid, bus.output_data, bus.input_ready);
        end
        tests++;
        if (out_q.size() != 1 || acc_q.size() != 1) begin
            fails++;
            $display("FAIL backpressure_count got results=%0d accepts=%0d need 1/1", out_q.size(), acc_q.size());
        end else begin
            tests++;
            if (out_q[0] !== 8'h01) begin
                fails++;
                $display("FAIL backpressure_data got %02h need 01", out_q[0]);
            end else $display("[TB] backpressure in=7C out=%02h", out_q[0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        clear_queues();
        bus.output_ready = 1'b1;
        push_byte(8'hED);
        step(); step();
        reset = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (bus.output_valid !== 1'b0 || bus.output_data !== 8'h00 || bus.input_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state got valid=%b data=%02h ready=%b need 0/00/1",
                     bus.output_valid, bus.output_data, bus.input_ready);
        end
        step();
        reset = 1'b0;
        repeat (12) step();
        tests++;
        if (out_q.size() != 0) begin
            fails++;
            $display("FAIL midreset_stale got %0d results need 0", out_q.size());
        end
        exp_q.push_back(8'hFF);
        push_byte(8'h16);
        drain(1);
        if (out_q.size() > 0) begin
            logic [7:0] got = out_q.pop_front();
            logic [7:0] want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL midreset_fresh got %02h need %02h", got, want);
            end else $display("[TB] midreset fresh in=16 out=%02h", got);
        end
    endtask

    task automatic test_exhaustive();
        clear_queues();
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    in_q.push_back(8'(i));
                    exp_q.push_back(inv_tab[i]);
                    push_byte(8'(i));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    step();
                    bus.output_ready = 1'($urandom_range(0, 1));
                end
                bus.output_ready = 1'b1;
            end
        join
        drain(256);
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got = out_q.pop_front();
            logic [7:0] want = exp_q.pop_front();
            logic [7:0] src = in_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL exhaustive_data in=%02h got %02h need %02h", src, got, want);
            end
            tests++;
            if (fwd_tab[got] !== src) begin
                fails++;
                $display("FAIL exhaustive_roundtrip in=%02h sbox(out=%02h)=%02h need %02h", src, got, fwd_tab[got], src);
            end
        end
        $display("[TB] exhaustive 256 bytes checked");
    endtask

    task automatic test_input_toggle();
        clear_queues();
        bus.output_ready = 1'b0;
        exp_q.push_back(8'h48);
        push_byte(8'h52);
        for (int k = 0; k < 16; k++) begin
            bus.input_data = 8'($urandom);
            if (k == 11) bus.output_ready = 1'b1;
            step();
        end
        drain(1);
        if (out_q.size() > 0) begin
            logic [7:0] got = out_q.pop_front();
            logic [7:0] want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL toggle_data got %02h need %02h", got, want);
            end else $display("[TB] toggle in=52 out=%02h", got);
        end
        tests++;
        if (acc_q.size() != 1) begin
            fails++;
            $display("FAIL toggle_accepts got %0d need 1", acc_q.size());
        end
    endtask

    initial begin
        bus.input_valid = 1'b0; bus.input_data = 8'h00; bus.output_ready = 1'b0;
        build_model();
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        test_input_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
